// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default constants and majority helper.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_OVERSAMPLE = 16;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchronizer plus 3-sample majority vote over the latest oversample ticks.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  input  logic ce_i,
  output logic rx_o,
  output logic bit_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0] hist_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      if (ce_i) hist_q <= {hist_q[0], rx_o};
    end
  assign rx_o = sync_q[SYNC_STAGES-1];
  // the current tick's sample joins the two stored ones, so the vote is ready on the tc=M+1 tick
  assign bit_o = maj3(hist_q[1], hist_q[0], rx_o);
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver with one-deep holding register.
// Optional parity state enabled by defining UART_RX_PARITY_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_ce,
  input  logic                 i_rdEnable,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frameError,
  output logic                 o_parityError,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  rx_state_t state_q, state_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic armed_q, armed_d, valid_q, valid_d, fe_q, fe_d, ovr_q, ovr_d;
  logic rx_s, smp, commit, rd, load;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d, pe_q, pe_d;
`endif
  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk_i (i_clock),
    .rst_ni(i_reset),
    .rx_i  (i_rx),
    .ce_i  (i_ce),
    .rx_o  (rx_s),
    .bit_o (smp)
  );
  always_comb begin
    state_d = state_q;
    tc_d = tc_q;
    idx_d = idx_q;
    sh_d = sh_q;
    armed_d = armed_q;
    commit = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d = perr_q;
`endif
    if (i_ce) begin
      tc_d = tc_q + 1'b1;
      case (state_q)
        IDLE: begin
          tc_d = '0;
          // after a break the line must go high again before a new start is accepted
          armed_d = armed_q | rx_s;
          state_d = (armed_q && !rx_s) ? START : IDLE;
        end
        START:
          if (tc_q == T_MID && smp) begin
            state_d = IDLE;
            tc_d = '0;
          end else if (tc_q == T_END) begin
            state_d = DATA;
            tc_d = '0;
            idx_d = '0;
          end
        DATA: begin
          if (tc_q == T_MID) sh_d = {smp, sh_q[DATA_BITS-1:1]};
          if (tc_q == T_END) begin
            tc_d = '0;
            idx_d = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (idx_q == IW'(DATA_BITS - 1)) state_d = PARITY;
`else
            if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tc_q == T_MID) perr_d = smp ^ (^sh_q) ^ PARITY_ODD;
          if (tc_q == T_END) begin
            state_d = STOP;
            tc_d = '0;
          end
        end
`endif
        STOP:
          if (tc_q == T_MID) begin
            commit = 1'b1;
            state_d = IDLE;
            tc_d = '0;
            armed_d = smp;
          end
        default: state_d = IDLE;
      endcase
    end
  end
  assign rd = i_rdEnable & valid_q;
  assign load = commit & (~valid_q | rd);
  assign valid_d = commit | (valid_q & ~rd);
  assign ovr_d = ~rd & (ovr_q | (commit & valid_q));
  assign data_d = load ? sh_q : data_q;
  assign fe_d = load ? ~smp : fe_q;
`ifdef UART_RX_PARITY_EN
  assign pe_d = load ? perr_q : pe_q;
  assign o_parityError = pe_q;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      perr_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
      pe_q <= pe_d;
    end
`else
  assign o_parityError = 1'b0;
`endif
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state_q <= IDLE;
      tc_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      fe_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q <= tc_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      data_q <= data_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      fe_q <= fe_d;
      ovr_q <= ovr_d;
    end
  assign o_data = data_q;
  assign o_valid = valid_q;
  assign o_frameError = fe_q;
  assign o_overrun = ovr_q;
  assign o_busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed table plus corner sequences for uart_receiver (OVERSAMPLE=16, i_ce every 4 clocks).
module tb_uart_receiver;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, ce = 1'b0, rd = 1'b0;
  logic [7:0] data;
  logic valid, fe, pe, ovr, busy;
  int tests = 0, fails = 0;
  typedef struct {
    logic [7:0] d;
    logic stop, rdo;
    logic [7:0] xd;
    logic xv, xfe, xov;
  } vec_t;
  vec_t tv[6];
  always #5 clk = ~clk;
  uart_receiver dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx(rx), .i_ce(ce), .i_rdEnable(rd),
    .o_data(data), .o_valid(valid), .o_frameError(fe), .o_parityError(pe),
    .o_overrun(ovr), .o_busy(busy)
  );
  initial begin : ce_gen
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      ce = (k % 4 == 0);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    rx = b;
    repeat (64) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic send_par_frame(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic read_pulse();
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask
  initial begin : main
    int n;
    logic seen;
    tv[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    tv[1] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b0};
    tv[2] = '{8'h0F, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0};
    tv[3] = '{8'h33, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1};
    tv[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tv[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_fe", fe, 0);
    chk("rst_pe", pe, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(64);
    for (int i = 0; i < 6; i++) begin
      send_frame(tv[i].d, tv[i].stop);
      idle(32);
      @(negedge clk);
      chk($sformatf("v%0d_data", i), data, tv[i].xd);
      chk($sformatf("v%0d_valid", i), valid, tv[i].xv);
      chk($sformatf("v%0d_fe", i), fe, tv[i].xfe);
      chk($sformatf("v%0d_ovr", i), ovr, tv[i].xov);
      chk($sformatf("v%0d_pe", i), pe, 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
      if (tv[i].rdo) begin
        read_pulse();
        @(negedge clk);
        chk($sformatf("v%0d_rd_valid", i), valid, 0);
        chk($sformatf("v%0d_rd_ovr", i), ovr, 0);
      end
    end
    @(posedge clk);
    #1 rx = 1'b0;
    seen = 1'b0;
    repeat (24) begin
      @(posedge clk);
      #1 seen = seen | busy;
    end
    chk("glitch_busy_pulse", seen, 1);
    idle(80);
    @(negedge clk);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_valid", valid, 0);
    @(posedge clk);
    #1;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(32);
    @(negedge clk);
    chk("b2b_data", data, 8'hA3);
    chk("b2b_ovr", ovr, 1);
    chk("b2b_valid", valid, 1);
    read_pulse();
    @(posedge clk);
    #1;
    fork
      begin
        send_frame(8'hA3, 1'b1);
        send_frame(8'h3C, 1'b1);
      end
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1 n++;
        end while (!valid && n < 700);
        chk("b2b_first_commit_seen", valid, 1);
        if (valid) begin
          repeat (639) @(posedge clk);
          #1 rd = 1'b1;
          @(posedge clk);
          #1 rd = 1'b0;
        end
      end
    join
    idle(32);
    @(negedge clk);
    chk("rdcommit_data", data, 8'h3C);
    chk("rdcommit_valid", valid, 1);
    chk("rdcommit_ovr", ovr, 0);
    read_pulse();
    rx = 1'b0;
    repeat (1280) @(posedge clk);
    #1;
    idle(64);
    @(negedge clk);
    chk("break_valid", valid, 1);
    chk("break_data", data, 0);
    chk("break_fe", fe, 1);
    chk("break_ovr", ovr, 0);
    chk("break_busy", busy, 0);
    @(posedge clk);
    #1;
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (64 * 5 + 32) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_data", data, 0);
        chk("midrst_fe", fe, 0);
        chk("midrst_busy", busy, 0);
      end
    join
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(64);
    @(negedge clk);
    chk("postrst_valid", valid, 0);
    chk("postrst_busy", busy, 0);
    send_frame(8'h81, 1'b1);
    idle(32);
    @(negedge clk);
    chk("postrst_data", data, 8'h81);
    chk("postrst_valid2", valid, 1);
    chk("postrst_fe", fe, 0);
    read_pulse();
`ifdef UART_RX_PARITY_EN
    send_par_frame(8'h07, 1'b1);
    idle(32);
    @(negedge clk);
    chk("par_ok_data", data, 8'h07);
    chk("par_ok_pe", pe, 0);
    read_pulse();
    send_par_frame(8'h07, 1'b0);
    idle(32);
    @(negedge clk);
    chk("par_bad_data", data, 8'h07);
    chk("par_bad_pe", pe, 1);
    read_pulse();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
